ps2_rx_controller: RTL and testbench

//  Sequences PS/2 keyboard reception ahead of the mux path. Syncs ps2_clk/ps2_data,

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_s2p_shift.sv | 25 ++
 rtl/ps2_rx_controller.sv | 192 +++++++++++++++++++
 tb/tb_ps2_rx_controller.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
// FSM states and protocol byte constants.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DECODE
  } ps2_state_e;

  localparam logic [7:0] PS2_BREAK     = 8'hF0;
  localparam logic [7:0] PS2_EXT       = 8'hE0;
  localparam int         PS2_DATA_BITS = 8;

endpackage

// File: rtl/ps2_s2p_shift.sv
// Serial-to-parallel shift register for PS/2 data bits.
// Right shift, serial input enters the MSB (LSB-first protocol).
module ps2_s2p_shift
  import ps2_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     shift_en,
  input  logic                     si,
  output logic [PS2_DATA_BITS-1:0] po
);

  // shift register: clear has priority over shift
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      po <= '0;
    end else if (clr) begin
      po <= '0;
    end else if (shift_en) begin
      po <= {si, po[PS2_DATA_BITS-1:1]};
    end
  end

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 keyboard receiver: sync, frame check,
// E0/F0 prefix folding and a one-entry hold buffer.
module ps2_rx_controller
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  input  logic       clr_err,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       key_valid,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic                   r_clk_q;
  ps2_state_e             r_state;
  ps2_state_e             w_state_nxt;
  logic [BW-1:0]          r_bitcnt;
  logic [TW-1:0]          r_tcnt;
  logic                   r_parity;
  logic                   r_ext_pend;
  logic                   r_brk_pend;
  logic [7:0]             w_po;
  logic                   w_fall;
  logic                   w_data;
  logic                   w_clr;
  logic                   w_shift;
  logic                   w_bad;
  logic                   w_timeout;
  logic                   w_ok;
  logic                   w_emit;
  logic                   w_prefix;

  // idle-high line: synchronizers reset to 1 so reset gives no false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_clk_q    <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_q    <= r_clk_sync[SYNC_STAGES-1];
    end
  end

  assign w_fall = r_clk_q & ~r_clk_sync[SYNC_STAGES-1];
  assign w_data = r_dat_sync[SYNC_STAGES-1];
  assign w_ok   = (^{w_po, r_parity}) & w_data;

  assign w_timeout = (r_state != IDLE) && !w_fall &&
                     (r_tcnt == TW'(TIMEOUT_CYCLES - 1));

  assign w_prefix = (w_po == PS2_BREAK) || (w_po == PS2_EXT);
  assign w_emit   = (r_state == DECODE) && !w_prefix;

  ps2_s2p_shift u_s2p (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (w_clr),
    .shift_en (w_shift),
    .si       (w_data),
    .po       (w_po)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt != IDLE);
    end
  end

  // next state and frame control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_clr       = 1'b0;
    w_shift     = 1'b0;
    w_bad       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_fall && !w_data) begin
          w_state_nxt = DATA;
          w_clr       = 1'b1;
        end
      end
      DATA: begin
        if (w_fall) begin
          w_shift = 1'b1;
          if (r_bitcnt == BW'(PS2_DATA_BITS - 1))
            w_state_nxt = PARITY;
        end
      end
      PARITY: begin
        if (w_fall) w_state_nxt = STOP;
      end
      STOP: begin
        if (w_fall) begin
          if (w_ok) begin
            w_state_nxt = DECODE;
          end else begin
            w_bad       = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      DECODE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) begin
      w_bad       = 1'b1;
      w_state_nxt = IDLE;
    end
  end

  // bit counter, parity latch and inactivity counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bitcnt <= '0;
      r_parity <= 1'b0;
      r_tcnt   <= '0;
    end else begin
      if (w_clr) r_bitcnt <= '0;
      else if (w_shift) r_bitcnt <= r_bitcnt + 1'b1;
      if (r_state == PARITY && w_fall) r_parity <= w_data;
      if (r_state == IDLE || w_fall) r_tcnt <= '0;
      else r_tcnt <= r_tcnt + 1'b1;
    end
  end

  // prefix folding: pending flags live until a code or an error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (w_bad) begin
      r_ext_pend <= 1'b0;
      r_brk_pend <= 1'b0;
    end else if (r_state == DECODE) begin
      if (w_po == PS2_BREAK) begin
        r_brk_pend <= 1'b1;
      end else if (w_po == PS2_EXT) begin
        r_ext_pend <= 1'b1;
      end else begin
        r_ext_pend <= 1'b0;
        r_brk_pend <= 1'b0;
      end
    end
  end

  // hold buffer, sticky overrun and error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= '0;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= w_bad;
      if (w_emit && (!key_valid || key_ready)) begin
        key_code  <= w_po;
        key_ext   <= r_ext_pend;
        key_break <= r_brk_pend;
        key_valid <= 1'b1;
      end else if (key_ready) begin
        key_valid <= 1'b0;
      end
      if (w_emit && key_valid && !key_ready) overrun <= 1'b1;
      else if (clr_err) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_rx_controller.sv
// Directed bench for ps2_rx_controller.
// Frames are bit-banged on ps2_clk/ps2_data at a slow rate.
module tb_ps2_rx_controller;

  localparam int TMO = 300;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int err_cnt = 0;
  int e0;

  ps2_rx_controller #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key_ready (key_ready),
    .clr_err   (clr_err),
    .key_code  (key_code),
    .key_ext   (key_ext),
    .key_break (key_break),
    .key_valid (key_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rst_n && frame_err) err_cnt++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b,
                            input logic pflip,
                            input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(~^b ^ pflip);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic consume();
    @(negedge clk);
    key_ready = 1'b1;
    @(negedge clk);
    key_ready = 1'b0;
  endtask

  initial begin
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", key_valid, 0);
    chk("rst_code", key_code, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: 0x1C with latency check on the stop bit
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(e0_bit(8'h1C, i));
    ps2_bit(1'b0);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t1_valid_s1", key_valid, 0);
    chk("t1_busy_dec", busy, 1);
    @(posedge clk);
    #1;
    chk("t1_valid_s2", key_valid, 1);
    chk("t1_busy_done", busy, 0);
    @(negedge clk);
    ps2_clk = 1'b1;
    repeat (20) @(negedge clk);
    chk("t1_hold", key_valid, 1);
    chk("t1_code", key_code, 8'h1C);
    chk("t1_ext", key_ext, 0);
    chk("t1_brk", key_break, 0);
    consume();
    chk("t1_consumed", key_valid, 0);

    // 2: F0 1C -> single break event
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("t2_no_evt_f0", key_valid, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t2_valid", key_valid, 1);
    chk("t2_code", key_code, 8'h1C);
    chk("t2_brk", key_break, 1);
    chk("t2_ext", key_ext, 0);
    consume();
    chk("t2_consumed", key_valid, 0);

    // 3: E0 F0 75, then plain 75
    send_frame(8'hE0, 1'b0, 1'b1);
    send_frame(8'hF0, 1'b0, 1'b1);
    chk("t3_no_evt_pfx", key_valid, 0);
    send_frame(8'h75, 1'b0, 1'b1);
    chk("t3_code", key_code, 8'h75);
    chk("t3_ext", key_ext, 1);
    chk("t3_brk", key_break, 1);
    consume();
    send_frame(8'h75, 1'b0, 1'b1);
    chk("t3b_code", key_code, 8'h75);
    chk("t3b_ext", key_ext, 0);
    chk("t3b_brk", key_break, 0);
    consume();

    // 4: bad parity, bad stop, then good frame
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
    chk("t4_par_err", err_cnt - e0, 1);
    chk("t4_par_valid", key_valid, 0);
    chk("t4_par_busy", busy, 0);
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("t4_stop_err", err_cnt - e0, 1);
    chk("t4_stop_valid", key_valid, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t4_good_valid", key_valid, 1);
    chk("t4_good_code", key_code, 8'h1C);
    consume();

    // 5: E0 then truncated frame times out
    send_frame(8'hE0, 1'b0, 1'b1);
    e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    chk("t5_busy_mid", busy, 1);
    repeat (TMO + 20) @(negedge clk);
    chk("t5_tmo_err", err_cnt - e0, 1);
    chk("t5_busy", busy, 0);
    chk("t5_valid", key_valid, 0);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t5_code", key_code, 8'h1C);
    chk("t5_ext", key_ext, 0);
    consume();

    // 6: overrun, clear, reset mid-frame
    send_frame(8'h1C, 1'b0, 1'b1);
    send_frame(8'h32, 1'b0, 1'b1);
    chk("t6_code_held", key_code, 8'h1C);
    chk("t6_ovr", overrun, 1);
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    chk("t6_ovr_clr", overrun, 0);
    chk("t6_still_valid", key_valid, 1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    chk("t6_busy_mid", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", key_valid, 0);
    chk("t6_rst_code", key_code, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b1);
    chk("t6_post_valid", key_valid, 1);
    chk("t6_post_code", key_code, 8'h1C);
    chk("t6_post_ovr", overrun, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  function automatic logic e0_bit(input logic [7:0] b, input int i);
    return b[i];
  endfunction

endmodule
